// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
// Adds two W-bit operands (W = 4*NIBBLES) one 4-bit digit per clock, least
// significant nibble first, rippling the carry through a single register.
// The sum builds up in S; the top nibble's carry-out lands in C4 and is
// flagged by a one-cycle done pulse. S and C4 then hold until the next start.

module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   C0,
    output logic                   ready,
    output logic                   busy,
    output logic [4*NIBBLES-1:0]   S,
    output logic                   C4,
    output logic                   done
);

    // The index only has to reach NIBBLES-1; keep at least one bit for NIBBLES=1.
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [NIBBLES-1:0][3:0]      a_q, a_d;
    logic [NIBBLES-1:0][3:0]      b_q, b_d;
    logic [NIBBLES-1:0][3:0]      s_q, s_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         carry_q, carry_d;
    logic                         c4_q, c4_d;
    logic [4:0]                   nib_sum;

    // One digit of the ripple: selected nibbles of A and B plus the running carry.
    always_comb begin
        nib_sum = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + {4'b0000, carry_q};
    end

    // Next-state and datapath updates for the IDLE -> ADD -> DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        c4_d    = c4_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    s_d     = '0;
                    carry_d = C0;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end

            ADD: begin
                s_d[idx_q] = nib_sum[3:0];
                carry_d    = nib_sum[4];
                if (idx_q == LAST_IDX) begin
                    // Park the index at 0 instead of stepping past the top nibble.
                    c4_d    = nib_sum[4];
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any addition in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c4_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            c4_q    <= c4_d;
        end
    end

    // Status flags decode straight from the state register so reset clears them at once.
    always_comb begin
        ready = (state_q == IDLE);
        busy  = (state_q == ADD);
        done  = (state_q == DONE);
        S     = s_q;
        C4    = c4_q;
    end

endmodule
